// File: rtl/line_cache_sched.sv
// Line cache bank scheduler between GBA capture and the HDMI image generator.
// Optional statistics counters are enabled by defining LINE_CACHE_STATS_EN.
module line_cache_sched #(
    parameter int NUM_BANKS   = 4,
    parameter int GBA_LINES   = 160,
    parameter int PRIME_LINES = 2
) (
    input  logic                         pxlClk,
    input  logic                         rst,
    input  logic                         wrFrameStart,
    input  logic                         wrLineDone,
    input  logic                         nextLine,
    input  logic                         cacheUpdate,
    output logic [$clog2(NUM_BANKS)-1:0] wrBank,
    output logic [$clog2(NUM_BANKS)-1:0] prevBank,
    output logic [$clog2(NUM_BANKS)-1:0] curBank,
    output logic [$clog2(NUM_BANKS)-1:0] nextBank,
    output logic                         sameLine,
    output logic                         newFrameOut,
    output logic [7:0]                   readLine,
    output logic                         overrun,
    output logic                         underrun
`ifdef LINE_CACHE_STATS_EN
    ,
    output logic [15:0]                  repeatCnt,
    output logic [7:0]                   resyncCnt
`endif
);

    localparam int BW = $clog2(NUM_BANKS);
    localparam logic [8:0] FULL    = 9'(GBA_LINES);
    localparam logic [8:0] LAST    = 9'(GBA_LINES - 1);
    localparam logic [8:0] PRIME_N = 9'(PRIME_LINES);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, RESYNC} state_t;

    state_t          state, state_n;
    logic [8:0]      written, written_n;
    logic [BW-1:0]   wr_bank_n, prev_n, cur_n, next_n, wr_inc;
    logic [7:0]      read_n;
    logic [8:0]      rl9, rn9;
    logic            pending, pending_n;
    logic            start_pend, start_pend_n;
    logic            same_now, same_n, new_frame_n, over_n, under_n;

    always_comb begin
        state_n      = state;
        written_n    = written;
        wr_bank_n    = wrBank;
        prev_n       = prevBank;
        cur_n        = curBank;
        next_n       = nextBank;
        read_n       = readLine;
        pending_n    = pending;
        start_pend_n = start_pend;
        new_frame_n  = 1'b0;
        over_n       = overrun;
        under_n      = underrun;
        wr_inc       = wrBank + BW'(1);
        rl9          = {1'b0, readLine};

        // A completed write is accounted before any read-side decision this cycle.
        if (wrLineDone) begin
            wr_bank_n = wr_inc;
            if (written != FULL)
                written_n = written + 9'd1;
            if (state == RUN && wr_inc == prevBank)
                over_n = 1'b1;
        end

        same_now = (written_n <= rl9 + 9'd1) && (rl9 < LAST);
        if (nextLine && (state != RUN || same_now))
            under_n = 1'b1;

        case (state)
            IDLE: begin
                if (wrFrameStart) begin
                    state_n   = PRIME;
                    written_n = '0;
                    wr_bank_n = '0;
                end
            end
            PRIME: begin
                if (wrFrameStart) begin
                    written_n = '0;
                    wr_bank_n = '0;
                end else if (cacheUpdate && written_n >= PRIME_N) begin
                    state_n      = RUN;
                    prev_n       = '0;
                    cur_n        = '0;
                    next_n       = BW'(1);
                    read_n       = '0;
                    new_frame_n  = 1'b1;
                    pending_n    = 1'b0;
                    start_pend_n = 1'b0;
                end
            end
            RUN: begin
                if (wrFrameStart) begin
                    if (rl9 != LAST && written_n != FULL) begin
                        state_n   = RESYNC;
                        written_n = '0;
                        wr_bank_n = '0;
                        pending_n = 1'b0;
                    end else begin
                        // Regular vsync while the reader finishes the frame: prime once it is done.
                        start_pend_n = 1'b1;
                    end
                end
                if (state_n == RUN) begin
                    if (nextLine && !same_now && !pending) begin
                        if (rl9 == LAST) begin
                            if (start_pend_n) begin
                                state_n   = PRIME;
                                written_n = '0;
                                wr_bank_n = '0;
                            end else begin
                                state_n = IDLE;
                            end
                        end else begin
                            pending_n = 1'b1;
                        end
                    end
                    if (cacheUpdate && pending) begin
                        pending_n = 1'b0;
                        prev_n    = curBank;
                        cur_n     = nextBank;
                        read_n    = readLine + 8'd1;
                        next_n    = (rl9 + 9'd1 == LAST) ? nextBank : nextBank + BW'(1);
                    end
                end
            end
            RESYNC: begin
                if (cacheUpdate)
                    state_n = PRIME;
            end
            default: state_n = IDLE;
        endcase

        rn9    = {1'b0, read_n};
        same_n = (state_n != RUN) || ((written_n <= rn9 + 9'd1) && (rn9 < LAST));
    end

    always_ff @(posedge pxlClk) begin
        if (!rst) begin
            state       <= IDLE;
            written     <= '0;
            wrBank      <= '0;
            prevBank    <= '0;
            curBank     <= '0;
            nextBank    <= BW'(1);
            readLine    <= '0;
            pending     <= 1'b0;
            start_pend  <= 1'b0;
            sameLine    <= 1'b0;
            newFrameOut <= 1'b0;
            overrun     <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_n;
            written     <= written_n;
            wrBank      <= wr_bank_n;
            prevBank    <= prev_n;
            curBank     <= cur_n;
            nextBank    <= next_n;
            readLine    <= read_n;
            pending     <= pending_n;
            start_pend  <= start_pend_n;
            sameLine    <= same_n;
            newFrameOut <= new_frame_n;
            overrun     <= over_n;
            underrun    <= under_n;
        end
    end

`ifdef LINE_CACHE_STATS_EN
    always_ff @(posedge pxlClk) begin
        if (!rst) begin
            repeatCnt <= '0;
            resyncCnt <= '0;
        end else begin
            if (state == RUN && cacheUpdate && sameLine && repeatCnt != 16'hFFFF)
                repeatCnt <= repeatCnt + 16'd1;
            if (state == RUN && state_n == RESYNC && resyncCnt != 8'hFF)
                resyncCnt <= resyncCnt + 8'd1;
        end
    end
`endif

endmodule

// File: doc/line_cache_sched.md
Name: line_cache_sched

Overview:
- Controller for the multi-bank GBA line cache that sits between the capture front end and the HDMI image generator.
- Tracks which bank the capture side is writing and which banks are presented as prev/cur/next line to the scaler/smoother.
- Generates the sameLine hold and the newFrame signal consumed by the image generator.
- Detects over/underrun and resyncs on a mid-line frame restart (in-game reset).

Parameters:
- NUM_BANKS, 4, number of line buffers in the ring (power of two, ≥4).
- GBA_LINES, 160, visible lines per GBA frame.
- PRIME_LINES, 2, lines that must be written before reading may start.

Ports:
- pxlClk  in  1  pixel clock.
- rst  in  1  synchronous reset, active-low.
- wrFrameStart  in  1  one-cycle pulse from capture at GBA vsync.
- wrLineDone  in  1  one-cycle pulse when capture finishes writing a line.
- nextLine  in  1  one-cycle pulse from the image generator requesting advance to the next GBA line.
- cacheUpdate  in  1  one-cycle pulse at end of active HDMI line; bank outputs change only on this pulse.
- wrBank  out  log2(NUM_BANKS)  bank capture writes into.
- prevBank, curBank, nextBank  out  log2(NUM_BANKS) each  banks presented to the read side.
- sameLine  out  1  next line not yet available; the read side must repeat the current line.
- newFrameOut  out  1  one-cycle pulse when reading of GBA line 0 begins.
- readLine  out  8  GBA line index currently presented as cur.
- overrun  out  1  sticky; a write would overtake the prev bank.
- underrun  out  1  sticky; nextLine was received while sameLine=1.

Behaviour:
- Reset (rst=0 at a pxlClk edge) takes effect in the same cycle, including mid-line:
  - all outputs 0; nextBank=1, prevBank=0; overrun/underrun cleared; state IDLE.
- Counters:
  - writtenLines 0..GBA_LINES.
  - wrBank advances modulo NUM_BANKS on each wrLineDone (wrap NUM_BANKS-1 → 0).
- States:
  - IDLE: wait for wrFrameStart → PRIME. writtenLines=0, wrBank=0.
  - PRIME: count wrLineDone. When writtenLines ≥ PRIME_LINES, on the next cacheUpdate:
    - set cur=0, prev=0 (line 0 duplicates itself as prev), next=1, readLine=0;
    - pulse newFrameOut for 1 cycle, one cycle after that cacheUpdate;
    - → RUN.
  - RUN:
    - nextLine accepted when sameLine=0. On the following cacheUpdate: prev←cur, cur←next, next←(next+1) mod NUM_BANKS, readLine+1.
    - On the last line (readLine=GBA_LINES-1): next=cur (bottom-edge duplicate), and a nextLine there → IDLE-wait for wrFrameStart with banks held.
    - wrFrameStart arriving while readLine ≠ GBA_LINES-1 and writtenLines ≠ GBA_LINES → RESYNC.
  - RESYNC: hold banks, sameLine=1 for one full line; reset counters as IDLE; → PRIME on the same wrFrameStart (not lost).
- sameLine (registered, 1-cycle latency):
  - 1 when writtenLines ≤ readLine+1 and readLine < GBA_LINES-1;
  - also 1 in IDLE, PRIME and RESYNC.
- Simultaneous events:
  - wrLineDone and nextLine in the same cycle: the write counts first, so sameLine evaluation sees the new line.
  - wrFrameStart and wrLineDone in the same cycle: the line completes the old frame, then the frame restarts.
- overrun: set when wrLineDone would make wrBank equal prevBank while in RUN. The write still proceeds; the flag is sticky until reset.
- Bank outputs are registered and glitch-free; they change only on the cycle after cacheUpdate.

Optional Feature:
- LINE_CACHE_STATS_EN defined:
  - adds outputs repeatCnt[15:0] (cacheUpdate cycles with sameLine=1 while in RUN) and resyncCnt[7:0] (RESYNC entries);
  - both saturate and are cleared by reset.
- Undefined: ports absent, no counters synthesized.

Test Plan:
- Reset then wrFrameStart, 2× wrLineDone, cacheUpdate → newFrameOut pulses once; cur=0, prev=0, next=1, readLine=0, sameLine=0.
- Steady frame: 160 wrLineDone interleaved at least 1 line ahead of 160 nextLine/cacheUpdate pairs → banks rotate mod 4, readLine reaches 159 with next==cur, underrun=0, overrun=0.
- Slow writer: read reaches readLine=writtenLines-1 → sameLine=1; an extra nextLine sets underrun=1 and banks do not move.
- wrFrameStart at readLine=40 → RESYNC, sameLine=1 for one cacheUpdate, then PRIME; newFrameOut after 2 new lines; with LINE_CACHE_STATS_EN, resyncCnt=1.
- Writer 4 lines ahead (wrBank wraps onto prevBank) → overrun=1 and stays 1.
- rst=0 mid-RUN at readLine=77 → next cycle all outputs at reset values, state IDLE; a new frame primes normally.
